// File: rtl/shmem_arb_pkg.sv
// Shared types and defaults for the two-requester shared-memory arbiter.
// Optional feature macro used by this block: SHMEM_ARB_ROUND_ROBIN_EN.
package shmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;

    // Arbiter sequencing: only IDLE looks at requests.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_e;

    // Latched operation of the granted transfer.
    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } op_e;

    // A requester is pending when it asks for either a read or a write.
    function automatic logic is_pending(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/shmem_arb_pick.sv
// Combinational winner select between two pending requesters.
// SHMEM_ARB_ROUND_ROBIN_EN defined: contention goes to the requester that
// did not win last time; undefined: requester 0 always wins contention.
module shmem_arb_pick (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    // Pick one requester out of the pending pair.
    always_comb begin
        valid = |pending;
`ifdef SHMEM_ARB_ROUND_ROBIN_EN
        if (&pending) begin
            winner = ~last_grant;
        end else begin
            winner = pending[1];
        end
`else
        winner = ~pending[0];
`endif
    end

`ifndef SHMEM_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the previous winner.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/shmem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Writes complete one cycle after sampling, reads two cycles after.
// SHMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module shmem_arbiter
    import shmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_waitrequest,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_waitrequest,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic [1:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic [1:0]          pending;
    logic                pick_valid;
    logic                pick_winner;

    assign pending = {is_pending(m1_read, m1_write), is_pending(m0_read, m0_write)};

    shmem_arb_pick u_pick (
        .pending    (pending),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Next-state and next-output computation; memory strobes and
    // waitrequests are produced one state ahead so they leave flops.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        wait_d       = '1;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    if (pick_winner) begin
                        addr_d  = m1_address;
                        be_d    = m1_byteenable;
                        wdata_d = m1_writedata;
                        op_d    = m1_write ? WR : RD;
                    end else begin
                        addr_d  = m0_address;
                        be_d    = m0_byteenable;
                        wdata_d = m0_writedata;
                        op_d    = m0_write ? WR : RD;
                    end
                    cs_d = 1'b1;
                    we_d = (op_d == WR);
                    // Write acknowledge coincides with the RAM strobe cycle.
                    if (op_d == WR) begin
                        wait_d[pick_winner] = 1'b0;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (op_q == WR) begin
                    state_d = IDLE;
                end else begin
                    wait_d[grant_q] = 1'b0;
                    state_d         = RDATA;
                end
            end
            RDATA: begin
                // Keep the returned word so readdata holds it afterwards.
                if (grant_q) begin
                    m1_rdata_d = mem_readdata;
                end else begin
                    m0_rdata_d = mem_readdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= RD;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            wait_q       <= '1;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            wait_q       <= wait_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = we_q;
    assign mem_clken      = reset_n;

    assign m0_waitrequest = wait_q[0];
    assign m1_waitrequest = wait_q[1];

    // RAM data is only valid during RDATA, so it bypasses the hold register then.
    assign m0_readdata = (state_q == RDATA && !grant_q) ? mem_readdata : m0_rdata_q;
    assign m1_readdata = (state_q == RDATA &&  grant_q) ? mem_readdata : m1_rdata_q;

endmodule

// File: tb/tb_shmem_arbiter.sv
// Scoreboard bench for shmem_arbiter: expected completions and RAM accesses
// are queued at issue time and popped by monitors on the falling edge.
module tb_shmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [7:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [7:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct { int cyc; bit rd; logic [31:0] data; } mexp_t;
    typedef struct { int cyc; bit wr; logic [7:0] addr; logic [3:0] be; logic [31:0] data; } memexp_t;

    mexp_t   mq0[$];
    mexp_t   mq1[$];
    memexp_t memq[$];

    shmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_address     (m0_address),
        .m0_byteenable  (m0_byteenable),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_byteenable  (m1_byteenable),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: one-cycle registered read, byte-lane writes.
    logic [31:0] ram [256];
    logic [31:0] ram_rd;
    logic [31:0] ram_w;
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h5A5A0000 | i;
        ram_rd = '0;
    end
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                ram_w = ram[mem_address];
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram_w[8*b +: 8] = mem_writedata[8*b +: 8];
                ram[mem_address] <= ram_w;
            end else begin
                ram_rd <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_m(input int m, input int c, input bit rd, input logic [31:0] d);
        mexp_t e;
        e.cyc = c; e.rd = rd; e.data = d;
        if (m == 0) mq0.push_back(e); else mq1.push_back(e);
    endtask

    task automatic push_mem(input int c, input bit wr, input logic [7:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        memexp_t e;
        e.cyc = c; e.wr = wr; e.addr = a; e.be = be; e.data = d;
        memq.push_back(e);
    endtask

    // Requester-side monitor: every low waitrequest must match a queued completion.
    task automatic mon_ack(input int m, input logic [31:0] rdata);
        mexp_t e;
        bit    empty;
        tests++;
        empty = (m == 0) ? (mq0.size() == 0) : (mq1.size() == 0);
        if (empty) begin
            fails++;
            $display("FAIL m%0d_ack: unexpected completion at cycle %0d", m, cyc);
        end else begin
            if (m == 0) e = mq0.pop_front(); else e = mq1.pop_front();
            if (e.cyc != cyc || (e.rd && rdata !== e.data)) begin
                fails++;
                $display("FAIL m%0d_ack: cycle %0d data %h, expected cycle %0d data %h",
                         m, cyc, rdata, e.cyc, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        memexp_t me;
        if (reset_n) begin
            if (!m0_waitrequest) mon_ack(0, m0_readdata);
            if (!m1_waitrequest) mon_ack(1, m1_readdata);
            if (mem_chipselect) begin
                tests++;
                if (memq.size() == 0) begin
                    fails++;
                    $display("FAIL mem_access: unexpected access at cycle %0d addr %h", cyc, mem_address);
                end else begin
                    me = memq.pop_front();
                    if (me.cyc != cyc || me.wr != mem_write || me.addr != mem_address ||
                        (me.wr && (me.be != mem_byteenable || me.data != mem_writedata))) begin
                        fails++;
                        $display("FAIL mem_access: cyc %0d wr %0b addr %h be %h data %h, expected cyc %0d wr %0b addr %h be %h data %h",
                                 cyc, mem_write, mem_address, mem_byteenable, mem_writedata,
                                 me.cyc, me.wr, me.addr, me.be, me.data);
                    end
                end
            end
        end
    end

    task automatic set_req(input int m, input bit rd, input bit wr, input logic [7:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    function automatic logic get_wait(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    // Called just after a rising edge; returns just after the edge that follows completion.
    task automatic xfer(input int m, input bit wr, input logic [7:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        int n = 0;
        set_req(m, !wr, wr, a, be, d);
        do begin
            @(negedge clk);
            n++;
        end while (get_wait(m) && n < 30);
        if (get_wait(m)) begin
            tests++;
            fails++;
            $display("FAIL m%0d_timeout: no completion within %0d cycles, addr %h", m, n, a);
        end
        @(posedge clk);
        #1;
        set_req(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        reset_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        chk("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("rst_we", {31'd0, mem_write}, 32'd0);
        chk("rst_addr", {24'd0, mem_address}, 32'd0);
        chk("rst_be", {28'd0, mem_byteenable}, 32'd0);
        chk("rst_wdata", mem_writedata, 32'd0);
        chk("rst_clken", {31'd0, mem_clken}, 32'd0);
        chk("rst_m0_rdata", m0_readdata, 32'd0);
        chk("rst_m1_rdata", m1_readdata, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("clken_run", {31'd0, mem_clken}, 32'd1);

        // Simultaneous writes: m0 first (last_grant=1 after reset / fixed priority)
        @(posedge clk); #1;
        c0 = cyc;
        push_mem(c0 + 1, 1, 8'h40, 4'hF, 32'h01010101);
        push_mem(c0 + 3, 1, 8'h41, 4'hF, 32'h02020202);
        push_m(0, c0 + 1, 0, '0);
        push_m(1, c0 + 3, 0, '0);
        fork
            xfer(0, 1, 8'h40, 4'hF, 32'h01010101);
            xfer(1, 1, 8'h41, 4'hF, 32'h02020202);
        join

        // Both requesters reading continuously, two reads each
        c0 = cyc;
`ifdef SHMEM_ARB_ROUND_ROBIN_EN
        push_mem(c0 + 1, 0, 8'h40, '0, '0);
        push_mem(c0 + 4, 0, 8'h05, '0, '0);
        push_mem(c0 + 7, 0, 8'h41, '0, '0);
        push_mem(c0 + 10, 0, 8'h06, '0, '0);
        push_m(0, c0 + 2, 1, 32'h01010101);
        push_m(0, c0 + 8, 1, 32'h02020202);
        push_m(1, c0 + 5, 1, 32'h5A5A0005);
        push_m(1, c0 + 11, 1, 32'h5A5A0006);
`else
        push_mem(c0 + 1, 0, 8'h40, '0, '0);
        push_mem(c0 + 4, 0, 8'h41, '0, '0);
        push_mem(c0 + 7, 0, 8'h05, '0, '0);
        push_mem(c0 + 10, 0, 8'h06, '0, '0);
        push_m(0, c0 + 2, 1, 32'h01010101);
        push_m(0, c0 + 5, 1, 32'h02020202);
        push_m(1, c0 + 8, 1, 32'h5A5A0005);
        push_m(1, c0 + 11, 1, 32'h5A5A0006);
`endif
        fork
            begin
                xfer(0, 0, 8'h40, 4'hF, '0);
                xfer(0, 0, 8'h41, 4'hF, '0);
            end
            begin
                xfer(1, 0, 8'h05, 4'hF, '0);
                xfer(1, 0, 8'h06, 4'hF, '0);
            end
        join

        // Single write then read-back from the other requester
        c0 = cyc;
        push_mem(c0 + 1, 1, 8'h10, 4'hF, 32'hDEADBEEF);
        push_m(0, c0 + 1, 0, '0);
        xfer(0, 1, 8'h10, 4'hF, 32'hDEADBEEF);
        c0 = cyc;
        push_mem(c0 + 1, 0, 8'h10, '0, '0);
        push_m(1, c0 + 2, 1, 32'hDEADBEEF);
        xfer(1, 0, 8'h10, 4'hF, '0);

        // Byte-lane write merge, back-to-back writes then read
        c0 = cyc;
        push_mem(c0 + 1, 1, 8'h30, 4'hF, 32'h11223344);
        push_m(0, c0 + 1, 0, '0);
        push_mem(c0 + 3, 1, 8'h30, 4'h2, 32'h0000AB00);
        push_m(0, c0 + 3, 0, '0);
        push_mem(c0 + 5, 0, 8'h30, '0, '0);
        push_m(0, c0 + 6, 1, 32'h1122AB44);
        xfer(0, 1, 8'h30, 4'hF, 32'h11223344);
        xfer(0, 1, 8'h30, 4'h2, 32'h0000AB00);
        xfer(0, 0, 8'h30, 4'hF, '0);
        @(posedge clk); #1;
        chk("m0_rdata_hold", m0_readdata, 32'h1122AB44);
        chk("m1_rdata_hold", m1_readdata, 32'hDEADBEEF);

        // Reset during the ACCESS cycle of a read
        set_req(1, 1'b1, 1'b0, 8'h05, 4'hF, '0);
        @(posedge clk); #1;
        chk("abort_cs_before", {31'd0, mem_chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        chk("abort_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        chk("abort_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("abort_m1_rdata", m1_readdata, 32'd0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        push_mem(c0 + 1, 1, 8'h50, 4'hF, 32'hCAFEF00D);
        push_m(0, c0 + 1, 0, '0);
        push_mem(c0 + 3, 0, 8'h50, '0, '0);
        push_m(1, c0 + 4, 1, 32'hCAFEF00D);
        xfer(0, 1, 8'h50, 4'hF, 32'hCAFEF00D);
        xfer(1, 0, 8'h50, 4'hF, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("m0_queue_drained", mq0.size(), 32'd0);
        chk("m1_queue_drained", mq1.size(), 32'd0);
        chk("mem_queue_drained", memq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
